// File: rtl/rv32i_fetch_pkg.sv
// Shared definitions for the rv32i instruction-fetch front end:
// state encodings, response payload and decode-side constants.
package rv32i_fetch_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned TIMER_W = 8;

  // Reserved for a future flush-to-NOP option (addi x0, x0, 0).
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_HOLD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            misaligned;
    logic            bus_err;
  } fetch_resp_t;

  function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/rv32i_fetch.sv
// Instruction-fetch front end: turns committed next-PC strobes into strobe/ack
// memory transactions and hands the result to decode with valid/ready.
module rv32i_fetch
  import rv32i_fetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET    = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_fetch_req,
  input  logic [31:0] i_pc,
  input  logic        i_flush,
  output logic        o_inst_stb,
  output logic [31:0] o_inst_addr,
  input  logic        i_inst_ack,
  input  logic [31:0] i_inst_data,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic        o_misaligned,
  output logic        o_bus_err,
  output logic        o_busy
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ACK_TIMEOUT - 1);

  fetch_state_e        state, state_d;
  logic                pend_v, pend_v_d;
  logic [XLEN-1:0]     pend_pc, pend_pc_d;
  logic                discard, discard_d;
  logic [TIMER_W-1:0]  timer, timer_d;
  logic                stb, stb_d;
  logic [XLEN-1:0]     addr, addr_d;
  fetch_resp_t         resp, resp_d;
  logic                valid, valid_d;
  logic                busy, busy_d;
  logic                start;
  logic [XLEN-1:0]     start_pc;

  // Next-state and next-output logic; a flush always kills the pending PC first.
  always_comb begin
    state_d   = state;
    pend_v_d  = pend_v && !i_flush;
    pend_pc_d = pend_pc;
    discard_d = discard;
    timer_d   = timer;
    stb_d     = stb;
    addr_d    = addr;
    resp_d    = resp;
    valid_d   = valid;
    start     = 1'b0;
    start_pc  = i_fetch_req ? i_pc : pend_pc;

    case (state)
      FETCH_IDLE: start = i_fetch_req || pend_v_d;

      FETCH_REQ: begin
        if (i_fetch_req) begin
          pend_v_d  = 1'b1;
          pend_pc_d = i_pc;
        end
        if (i_inst_ack || timer == TIMER_LAST) begin
          stb_d     = 1'b0;
          discard_d = 1'b0;
          if (discard || i_flush) begin
            state_d = FETCH_IDLE;
          end else begin
            state_d           = FETCH_HOLD;
            valid_d           = 1'b1;
            resp_d.inst       = i_inst_ack ? i_inst_data : '0;
            resp_d.bus_err    = !i_inst_ack;
            resp_d.misaligned = 1'b0;
          end
        end else begin
          discard_d = discard || i_flush;
          if (timer != '1) timer_d = timer + TIMER_W'(1);
        end
      end

      FETCH_HOLD: begin
        if (i_flush || i_inst_ready) begin
          valid_d           = 1'b0;
          resp_d.misaligned = 1'b0;
          resp_d.bus_err    = 1'b0;
          state_d           = FETCH_IDLE;
          start             = i_fetch_req || pend_v_d;
        end else if (i_fetch_req) begin
          pend_v_d  = 1'b1;
          pend_pc_d = i_pc;
        end
      end

      default: state_d = FETCH_IDLE;
    endcase

    // Launch a fetch; a misaligned PC short-circuits straight to a faulted result.
    if (start) begin
      pend_v_d  = 1'b0;
      resp_d.pc = start_pc;
      if (pc_misaligned(start_pc)) begin
        state_d           = FETCH_HOLD;
        valid_d           = 1'b1;
        resp_d.inst       = '0;
        resp_d.misaligned = 1'b1;
        resp_d.bus_err    = 1'b0;
      end else begin
        state_d = FETCH_REQ;
        stb_d   = 1'b1;
        addr_d  = start_pc;
        timer_d = '0;
      end
    end

    busy_d = (state_d != FETCH_IDLE) || pend_v_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= FETCH_IDLE;
      pend_v  <= 1'b0;
      pend_pc <= PC_RESET;
      discard <= 1'b0;
      timer   <= '0;
      stb     <= 1'b0;
      addr    <= PC_RESET;
      resp    <= '{inst: '0, pc: PC_RESET, misaligned: 1'b0, bus_err: 1'b0};
      valid   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_d;
      pend_v  <= pend_v_d;
      pend_pc <= pend_pc_d;
      discard <= discard_d;
      timer   <= timer_d;
      stb     <= stb_d;
      addr    <= addr_d;
      resp    <= resp_d;
      valid   <= valid_d;
      busy    <= busy_d;
    end
  end

  assign o_inst_stb   = stb;
  assign o_inst_addr  = addr;
  assign o_inst       = resp.inst;
  assign o_inst_pc    = resp.pc;
  assign o_misaligned = resp.misaligned;
  assign o_bus_err    = resp.bus_err;
  assign o_inst_valid = valid;
  assign o_busy       = busy;

endmodule

// File: tb/tb_rv32i_fetch.sv
// Self-checking bench for rv32i_fetch: directed vector table, hand-written
// corner sequences, then randomized traffic against a transaction-level model.
module tb_rv32i_fetch;

  localparam int          TO     = 16;
  localparam logic [31:0] PC_RST = 32'h0000_0000;

  logic        clk, rst_n;
  logic        fetch_req, flush, inst_ack, inst_ready;
  logic [31:0] pc, inst_data;
  logic        inst_stb, inst_valid, misaligned, bus_err, busy;
  logic [31:0] inst_addr, inst, inst_pc;

  int n_tests = 0;
  int n_fail  = 0;

  rv32i_fetch #(.PC_RESET(PC_RST), .ACK_TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_fetch_req(fetch_req), .i_pc(pc),
    .i_flush(flush), .o_inst_stb(inst_stb), .o_inst_addr(inst_addr),
    .i_inst_ack(inst_ack), .i_inst_data(inst_data), .o_inst(inst),
    .o_inst_pc(inst_pc), .o_inst_valid(inst_valid), .i_inst_ready(inst_ready),
    .o_misaligned(misaligned), .o_bus_err(bus_err), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle_in();
    fetch_req = 1'b0; pc = '0; flush = 1'b0;
    inst_ack = 1'b0; inst_data = '0; inst_ready = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        req;   logic [31:0] pc;
    logic        ack;   logic [31:0] data;  logic ready;
    logic        e_stb; logic [31:0] e_addr; logic e_valid;
    logic [31:0] e_inst; logic [31:0] e_pc;
    logic        e_mis; logic e_err; logic e_busy;
  } vec_t;

  function automatic vec_t mk(input logic req, input logic [31:0] p, input logic ack,
                              input logic [31:0] d, input logic rdy, input logic s,
                              input logic [31:0] a, input logic v, input logic [31:0] i,
                              input logic [31:0] ip, input logic m, input logic e,
                              input logic b);
    vec_t r;
    r.req = req; r.pc = p; r.ack = ack; r.data = d; r.ready = rdy;
    r.e_stb = s; r.e_addr = a; r.e_valid = v; r.e_inst = i; r.e_pc = ip;
    r.e_mis = m; r.e_err = e; r.e_busy = b;
    return r;
  endfunction

  // ---------------- reference model ----------------
  logic        m_stb, m_valid, m_mis, m_err, m_discard;
  logic [31:0] m_addr, m_inst, m_pc;
  int          m_waited;
  logic [31:0] m_pend[$];

  task automatic model_reset();
    m_stb = 0; m_valid = 0; m_mis = 0; m_err = 0; m_discard = 0;
    m_addr = PC_RST; m_inst = '0; m_pc = PC_RST; m_waited = 0;
    m_pend.delete();
  endtask

  task automatic model_step(input logic req, input logic [31:0] p, input logic fl,
                            input logic ack, input logic [31:0] d, input logic rdy);
    bit          go = 0;
    logic [31:0] spc = p;
    if (fl) m_pend.delete();
    if (m_stb) begin
      if (fl) m_discard = 1;
      if (ack || m_waited == TO - 1) begin
        m_stb = 0;
        if (m_discard) m_discard = 0;
        else begin
          m_valid = 1; m_inst = ack ? d : 32'h0; m_err = !ack; m_mis = 0;
        end
      end else m_waited++;
      if (req) begin m_pend.delete(); m_pend.push_back(p); end
    end else begin
      if (m_valid && (fl || rdy)) begin m_valid = 0; m_mis = 0; m_err = 0; end
      if (!m_valid) begin
        if (req) begin go = 1; spc = p; end
        else if (m_pend.size() > 0) begin go = 1; spc = m_pend[0]; end
      end else if (req) begin
        m_pend.delete(); m_pend.push_back(p);
      end
    end
    if (go) begin
      m_pend.delete();
      m_pc = spc;
      if (spc[1:0] != 2'b00) begin
        m_valid = 1; m_mis = 1; m_inst = '0; m_err = 0;
      end else begin
        m_stb = 1; m_addr = spc; m_waited = 0;
      end
    end
  endtask

  initial begin
    vec_t vecs[9];
    int   cnt;
    idle_in();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_stb", 32'(inst_stb), 0);
    chk("rst_addr", inst_addr, PC_RST);
    chk("rst_pc", inst_pc, PC_RST);
    chk("rst_inst", inst, 0);
    chk("rst_valid", 32'(inst_valid), 0);
    chk("rst_flags", {30'h0, misaligned, bus_err}, 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;

    // 0x100 with three wait cycles, then a misaligned PC
    vecs[0] = mk(1, 32'h100, 0, 0, 0,           0, 32'h0,   0, 0, 0, 0, 0, 0);
    vecs[1] = mk(0, 0, 0, 0, 0,                 1, 32'h100, 0, 0, 0, 0, 0, 1);
    vecs[2] = mk(0, 0, 0, 0, 0,                 1, 32'h100, 0, 0, 0, 0, 0, 1);
    vecs[3] = mk(0, 0, 0, 0, 0,                 1, 32'h100, 0, 0, 0, 0, 0, 1);
    vecs[4] = mk(0, 0, 1, 32'h00500093, 0,      1, 32'h100, 0, 0, 0, 0, 0, 1);
    vecs[5] = mk(0, 0, 0, 0, 1,                 0, 32'h100, 1, 32'h00500093, 32'h100, 0, 0, 1);
    vecs[6] = mk(1, 32'h102, 0, 0, 0,           0, 32'h100, 0, 0, 0, 0, 0, 0);
    vecs[7] = mk(0, 0, 0, 0, 1,                 0, 32'h100, 1, 32'h0, 32'h102, 1, 0, 1);
    vecs[8] = mk(0, 0, 0, 0, 0,                 0, 32'h100, 0, 0, 0, 0, 0, 0);
    for (int r = 0; r < 9; r++) begin
      @(negedge clk);
      chk($sformatf("vec%0d_stb", r), 32'(inst_stb), 32'(vecs[r].e_stb));
      chk($sformatf("vec%0d_addr", r), inst_addr, vecs[r].e_addr);
      chk($sformatf("vec%0d_valid", r), 32'(inst_valid), 32'(vecs[r].e_valid));
      chk($sformatf("vec%0d_busy", r), 32'(busy), 32'(vecs[r].e_busy));
      if (vecs[r].e_valid) begin
        chk($sformatf("vec%0d_inst", r), inst, vecs[r].e_inst);
        chk($sformatf("vec%0d_pc", r), inst_pc, vecs[r].e_pc);
        chk($sformatf("vec%0d_mis", r), 32'(misaligned), 32'(vecs[r].e_mis));
        chk($sformatf("vec%0d_err", r), 32'(bus_err), 32'(vecs[r].e_err));
      end
      fetch_req = vecs[r].req; pc = vecs[r].pc; inst_ack = vecs[r].ack;
      inst_data = vecs[r].data; inst_ready = vecs[r].ready;
    end
    idle_in();

    // ack timeout: strobe held exactly TO cycles
    @(negedge clk); fetch_req = 1; pc = 32'h300;
    @(negedge clk); fetch_req = 0;
    cnt = 0;
    while (inst_stb && cnt < 300) begin cnt++; @(negedge clk); end
    chk("to_stb_cycles", 32'(cnt), 32'(TO));
    chk("to_valid", 32'(inst_valid), 1);
    chk("to_err", 32'(bus_err), 1);
    chk("to_inst", inst, 0);
    chk("to_pc", inst_pc, 32'h300);
    inst_ready = 1; @(negedge clk); inst_ready = 0;

    // HOLD stall with a new request queued behind it
    fetch_req = 1; pc = 32'h400;
    @(negedge clk); fetch_req = 0; inst_ack = 1; inst_data = 32'h1111_1111;
    @(negedge clk); inst_ack = 0;
    chk("hold_valid0", 32'(inst_valid), 1);
    fetch_req = 1; pc = 32'h200;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); fetch_req = 0;
      chk("hold_valid", 32'(inst_valid), 1);
      chk("hold_inst", inst, 32'h1111_1111);
      chk("hold_pc", inst_pc, 32'h400);
      chk("hold_busy", 32'(busy), 1);
      chk("hold_stb", 32'(inst_stb), 0);
    end
    inst_ready = 1;
    @(negedge clk); inst_ready = 0;
    chk("acc_valid", 32'(inst_valid), 0);
    chk("acc_stb", 32'(inst_stb), 1);
    chk("acc_addr", inst_addr, 32'h200);
    inst_ack = 1; inst_data = 32'h2222_2222;
    @(negedge clk); inst_ack = 0;
    chk("acc2_inst", inst, 32'h2222_2222);
    chk("acc2_pc", inst_pc, 32'h200);
    inst_ready = 1; @(negedge clk); inst_ready = 0;

    // flush in REQ with a trap PC the same cycle
    fetch_req = 1; pc = 32'h500;
    @(negedge clk); fetch_req = 0;
    @(negedge clk); flush = 1; fetch_req = 1; pc = 32'h80;
    @(negedge clk); flush = 0; fetch_req = 0;
    chk("fl_stb_held", 32'(inst_stb), 1);
    chk("fl_addr_held", inst_addr, 32'h500);
    inst_ack = 1; inst_data = 32'hdead_beef;
    @(negedge clk); inst_ack = 0;
    chk("fl_swallow_valid", 32'(inst_valid), 0);
    chk("fl_busy", 32'(busy), 1);
    @(negedge clk);
    chk("fl_trap_stb", 32'(inst_stb), 1);
    chk("fl_trap_addr", inst_addr, 32'h80);
    chk("fl_no_valid", 32'(inst_valid), 0);
    inst_ack = 1; inst_data = 32'h3333_3333;
    @(negedge clk); inst_ack = 0;
    chk("fl_trap_pc", inst_pc, 32'h80);
    chk("fl_trap_inst", inst, 32'h3333_3333);
    inst_ready = 1; @(negedge clk); inst_ready = 0;

    // asynchronous reset in the middle of a request with a pending PC
    fetch_req = 1; pc = 32'h600;
    @(negedge clk); pc = 32'h700;
    @(negedge clk); fetch_req = 0;
    chk("rr_stb_pre", 32'(inst_stb), 1);
    #2 rst_n = 0;
    #1;
    chk("rr_stb", 32'(inst_stb), 0);
    chk("rr_valid", 32'(inst_valid), 0);
    chk("rr_busy", 32'(busy), 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    chk("rr_no_stale", 32'(inst_stb), 0);
    fetch_req = 1; pc = 32'h900;
    @(negedge clk); fetch_req = 0;
    chk("rr_new_stb", 32'(inst_stb), 1);
    chk("rr_new_addr", inst_addr, 32'h900);
    inst_ack = 1; inst_data = 32'h4444_4444;
    @(negedge clk); inst_ack = 0;
    chk("rr_new_inst", inst, 32'h4444_4444);
    chk("rr_new_pc", inst_pc, 32'h900);

    // randomized traffic against the model
    rst_n = 0;
    @(negedge clk); rst_n = 1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic        r_req, r_fl, r_ack, r_rdy;
      logic [31:0] r_pc, r_d;
      @(negedge clk);
      chk("rnd_stb", 32'(inst_stb), 32'(m_stb));
      chk("rnd_addr", inst_addr, m_addr);
      chk("rnd_valid", 32'(inst_valid), 32'(m_valid));
      chk("rnd_busy", 32'(busy), 32'(m_stb || m_valid || m_pend.size() > 0));
      if (m_valid) begin
        chk("rnd_inst", inst, m_inst);
        chk("rnd_pc", inst_pc, m_pc);
        chk("rnd_mis", 32'(misaligned), 32'(m_mis));
        chk("rnd_err", 32'(bus_err), 32'(m_err));
      end
      r_req = ($urandom_range(0, 3) == 0);
      r_pc  = 32'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 7) == 0) r_pc[1:0] = 2'($urandom_range(1, 3));
      r_fl  = ($urandom_range(0, 19) == 0);
      r_rdy = ($urandom_range(0, 1) == 1);
      r_ack = inst_stb && ($urandom_range(0, 2) == 0);
      r_d   = $urandom;
      fetch_req = r_req; pc = r_pc; flush = r_fl;
      inst_ack = r_ack; inst_data = r_d; inst_ready = r_rdy;
      model_step(r_req, r_pc, r_fl, r_ack, r_d, r_rdy);
    end
    idle_in();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
